ifmap_skew_feeder: RTL and testbench

- Upstream stage of the PE systolic array.
- Accepts one ROWS-wide ifmap vector per cycle over a valid/ready handshake and issues it to the array's left edge with diagonal skew: lane r is delayed r cycles relative to lane 0.
- Drives the per-row ifmap load enable that each row's first PE uses to register its ifmap.
- Tracks frame boundaries, flushes the skew pipe after the last vector, and pulses done when the last element leaves lane ROWS-1.

---
 rtl/ifmap_skew_feeder.sv | 159 +++++++++++++++
 tb/tb_ifmap_skew_feeder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ifmap_skew_feeder.sv
// ifmap_skew_feeder: upstream stage of the PE systolic array.
// Accepts one ROWS-wide ifmap vector per cycle (valid/ready) and presents it
// to the array's left edge with diagonal skew: lane r is delayed r cycles
// relative to lane 0. Each lane carries its own load enable alongside the data.
// A last flag rides a ROWS-stage delay next to lane ROWS-1 and becomes done_o.
// After the last vector the FSM refuses input for ROWS-1 cycles while the
// skew pipe drains.
// Optional feature macro: SKEW_FRAME_CNT_EN adds a 16-bit wrapping frame
// counter on output frame_cnt_o (incremented once per done_o).

module ifmap_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] ifmap_o,
  output logic [ROWS-1:0]            ifmap_en_o,
  output logic                       busy_o,
`ifdef SKEW_FRAME_CNT_EN
  output logic [15:0]                frame_cnt_o,
`endif
  output logic                       done_o
);

  // Flush counter must hold ROWS-1; keep at least one bit for ROWS=1.
  localparam int              CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [ROWS-1:0]  last_q;
  logic             accept;

  // Ready depends only on state; it is also held low while reset is asserted.
  assign in_ready = ~rst & (state_q != ST_FLUSH);
  assign accept   = in_valid & in_ready;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = last_q[ROWS-1];

  // Frame-level state machine: IDLE/STREAM accept beats, FLUSH drains the skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (in_last) begin
              if (ROWS > 1) begin
                state_q     <= ST_FLUSH;
                flush_cnt_q <= CNT_LOAD;
              end else begin
                state_q     <= ST_IDLE;
              end
            end else begin
              state_q <= ST_STREAM;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_FLUSH: begin
          // Leaving on the count of one makes the IDLE cycle coincide with done_o.
          if (flush_cnt_q == CNT_ONE) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= CNT_ZERO;
          end else begin
            flush_cnt_q <= flush_cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          flush_cnt_q <= CNT_ZERO;
        end
      endcase
    end
  end

  // Last-flag delay line, same depth as lane ROWS-1, so done_o lines up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q[0] <= accept & in_last;
      for (int i = 1; i < ROWS; i++) begin
        last_q[i] <= last_q[i-1];
      end
    end
  end

  // Per-lane skew pipes: lane r is r+1 registers deep carrying {en, data}.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [r+1];
    logic [r:0]            en_q;
    logic [DATA_WIDTH-1:0] lane_d;

    // Accepted beats enter with their lane data; idle cycles insert a zero bubble.
    always_comb begin
      lane_d = '0;
      if (accept) begin
        lane_d = in_data[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        lane_d = '0;
      end
    end

    // Shift the lane pipe every cycle; the array never backpressures.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          dat_q[i] <= '0;
        end
        en_q <= '0;
      end else begin
        dat_q[0] <= lane_d;
        en_q[0]  <= accept;
        for (int i = 1; i <= r; i++) begin
          dat_q[i] <= dat_q[i-1];
          en_q[i]  <= en_q[i-1];
        end
      end
    end

    assign ifmap_o[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
    assign ifmap_en_o[r]                       = en_q[r];
  end

`ifdef SKEW_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count completed frames; wraps naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if (last_q[ROWS-1]) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Directed, table-driven bench for ifmap_skew_feeder with ROWS=4, DATA_WIDTH=8.
// Each table row gives the inputs driven during one cycle and the outputs
// expected during that same cycle (outputs only change on the rising edge).
module tb_ifmap_skew_feeder;

  localparam int DW   = 8;
  localparam int ROWS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 in_last;
  logic [ROWS*DW-1:0]   ifmap_o;
  logic [ROWS-1:0]      ifmap_en_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef SKEW_FRAME_CNT_EN
  logic [15:0]          frame_cnt_o;
`endif

  ifmap_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .ifmap_o    (ifmap_o),
    .ifmap_en_o (ifmap_en_o),
    .busy_o     (busy_o),
`ifdef SKEW_FRAME_CNT_EN
    .frame_cnt_o(frame_cnt_o),
`endif
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  en;
    logic [31:0] q;
    logic        dn;
    logic        bz;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic v, input logic l, input logic [31:0] d,
                     input logic rdy, input logic [3:0] en, input logic [31:0] q,
                     input logic dn, input logic bz);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.rdy = rdy; t.en = en; t.q = q; t.dn = dn; t.bz = bz;
    vecs.push_back(t);
  endtask

  task automatic check_out(input string name, input logic rdy, input logic [3:0] en,
                           input logic [31:0] q, input logic dn, input logic bz);
    checks++;
    if (in_ready !== rdy || ifmap_en_o !== en || ifmap_o !== q ||
        done_o !== dn || busy_o !== bz) begin
      errors++;
      $display("FAIL %s: got rdy=%b en=%b q=%h done=%b busy=%b, want rdy=%b en=%b q=%h done=%b busy=%b",
               name, in_ready, ifmap_en_o, ifmap_o, done_o, busy_o, rdy, en, q, dn, bz);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;

    // --- single vector with last
    add(1, 1, 32'h04030201, 1, 4'b0000, 32'h00000000, 0, 0);
    add(0, 0, 32'h0,        0, 4'b0001, 32'h00000001, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0010, 32'h00000200, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0100, 32'h00030000, 0, 1);
    add(0, 0, 32'h0,        1, 4'b1000, 32'h04000000, 1, 0);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0);
    // --- stream of three
    add(1, 0, 32'h0A0A0A0A, 1, 4'b0000, 32'h00000000, 0, 0);
    add(1, 0, 32'h0B0B0B0B, 1, 4'b0001, 32'h0000000A, 0, 1);
    add(1, 1, 32'h0C0C0C0C, 1, 4'b0011, 32'h00000A0B, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0111, 32'h000A0B0C, 0, 1);
    add(0, 0, 32'h0,        0, 4'b1110, 32'h0A0B0C00, 0, 1);
    add(0, 0, 32'h0,        0, 4'b1100, 32'h0B0C0000, 0, 1);
    add(0, 0, 32'h0,        1, 4'b1000, 32'h0C000000, 1, 0);
    add(0, 1, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0); // last without valid ignored
    // --- bubble between two vectors
    add(1, 0, 32'h13121110, 1, 4'b0000, 32'h00000000, 0, 0);
    add(0, 0, 32'h0,        1, 4'b0001, 32'h00000010, 0, 1);
    add(1, 1, 32'h23222120, 1, 4'b0010, 32'h00001100, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0101, 32'h00120020, 0, 1);
    add(0, 0, 32'h0,        0, 4'b1010, 32'h13002100, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0100, 32'h00220000, 0, 1);
    add(0, 0, 32'h0,        1, 4'b1000, 32'h23000000, 1, 0);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0);
    // --- valid held through FLUSH
    add(1, 1, 32'h34333231, 1, 4'b0000, 32'h00000000, 0, 0);
    add(1, 1, 32'hFFFFFFFF, 0, 4'b0001, 32'h00000031, 0, 1);
    add(1, 1, 32'hFFFFFFFF, 0, 4'b0010, 32'h00003200, 0, 1);
    add(1, 1, 32'hFFFFFFFF, 0, 4'b0100, 32'h00330000, 0, 1);
    add(1, 1, 32'hFFFFFFFF, 1, 4'b1000, 32'h34000000, 1, 0);
    add(0, 0, 32'h0,        0, 4'b0001, 32'h000000FF, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0010, 32'h0000FF00, 0, 1);
    add(0, 0, 32'h0,        0, 4'b0100, 32'h00FF0000, 0, 1);
    add(0, 0, 32'h0,        1, 4'b1000, 32'hFF000000, 1, 0);
    add(0, 0, 32'h0,        1, 4'b0000, 32'h00000000, 0, 0);

    // Reset state, sampled while rst is still high after two edges.
    @(posedge clk); @(posedge clk); #1;
    check_out("reset_state", 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v; in_last = vecs[i].l; in_data = vecs[i].d;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].en, vecs[i].q,
                vecs[i].dn, vecs[i].bz);
      @(posedge clk); #1;
    end

`ifdef SKEW_FRAME_CNT_EN
    checks++;
    if (frame_cnt_o !== 16'd5) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want 5", frame_cnt_o);
    end
`endif

    // --- reset mid-frame: two beats accepted, then a one-cycle reset
    in_valid = 1'b1; in_last = 1'b0; in_data = 32'h44434241;
    #1; check_out("rst_seq_a", 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_data = 32'h54535251;
    #1; check_out("rst_seq_b", 1'b1, 4'b0001, 32'h00000041, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; rst = 1'b1;
    #1; check_out("rst_seq_in_rst", 1'b0, 4'b0011, 32'h00004251, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1; check_out($sformatf("rst_seq_after%0d", k), 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
